// File: rtl/ps2_pkg.sv
// Shared constants, state encoding and small helpers for the PS2 keyboard
// command sequencer.
package ps2_pkg;

  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_LEDS     = 8'hED;

  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_RESEND   = 8'hFE;
  localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
  localparam logic [7:0] RSP_BAT_FAIL = 8'hFC;

  typedef enum logic [3:0] {
    RST_TX,
    RST_ACK,
    RST_BAT,
    IDLE,
    LED_TX,
    LED_ACK,
    ARG_TX,
    ARG_ACK,
    FAIL
  } state_t;

  function automatic logic is_response(input logic [7:0] b);
    return (b == RSP_ACK) || (b == RSP_RESEND) || (b == RSP_BAT_OK) || (b == RSP_BAT_FAIL);
  endfunction

  function automatic state_t tx_to_ack(input state_t s);
    case (s)
      RST_TX:  return RST_ACK;
      LED_TX:  return LED_ACK;
      default: return ARG_ACK;
    endcase
  endfunction

  function automatic state_t ack_to_tx(input state_t s);
    case (s)
      RST_ACK: return RST_TX;
      LED_ACK: return LED_TX;
      default: return ARG_TX;
    endcase
  endfunction

endpackage

// File: rtl/ps2_cmd_timer.sv
// Response timeout counter: runs while enabled, held at zero otherwise,
// and flags expiry on the cycle it reaches TIMEOUT_CYC-1.
module ps2_cmd_timer #(
  parameter int TIMEOUT_CYC = 4_800_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || clr_i || !en_i) begin
      r_cnt <= '0;
    end else if (r_cnt != LAST) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign expire_o = en_i && (r_cnt == LAST);

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS2 keyboard command sequencer: reset/BAT bring-up, LED writes with
// resend/timeout retries, and filtering of command responses from scancodes.
module ps2_kbd_ctrl
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYC = 4_800_000,
  parameter int MAX_RETRY   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_byte_i,
  input  logic       rx_valid_i,
  output logic [7:0] tx_byte_o,
  output logic       tx_valid_o,
  input  logic       tx_ready_i,
  input  logic [2:0] leds_i,
  input  logic       leds_update_i,
  input  logic       init_req_i,
  output logic [7:0] sc_byte_o,
  output logic       sc_valid_o,
  output logic       kbd_ok_o,
  output logic       busy_o,
  output logic       err_o
);

  localparam int RW = $clog2(MAX_RETRY + 2);

  state_t        r_state, w_state_next;
  logic [7:0]    r_tx_byte, w_tx_byte_next;
  logic          r_tx_valid, w_tx_valid_next;
  logic [7:0]    r_sc_byte, w_sc_byte_next;
  logic          r_sc_valid, w_sc_valid_next;
  logic          r_kbd_ok, w_kbd_ok_next;
  logic          r_err, w_err_next;
  logic [2:0]    r_led_shadow, w_led_shadow_next;
  logic          r_led_pending, w_led_pending_next;
  logic [RW-1:0] r_retry, w_retry_next;

  logic w_tmr_clr, w_tmr_en, w_expire;
  logic w_accept, w_rx_ack, w_nack, w_forward, w_led_start;

  ps2_cmd_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (w_tmr_clr),
    .en_i     (w_tmr_en),
    .expire_o (w_expire)
  );

  assign w_tmr_en = (r_state == RST_ACK) || (r_state == LED_ACK) || (r_state == ARG_ACK);
  assign w_accept = r_tx_valid && tx_ready_i;
  assign w_rx_ack = rx_valid_i && (rx_byte_i == RSP_ACK);
  // A resend byte and an expiry in the same cycle have the same effect.
  assign w_nack   = (rx_valid_i && (rx_byte_i == RSP_RESEND)) || w_expire;
  assign w_forward = rx_valid_i && (r_state != FAIL) &&
                     ((r_state == IDLE) ? (rx_byte_i != RSP_BAT_OK) : !is_response(rx_byte_i));

  always_comb begin
    w_state_next       = r_state;
    w_tx_byte_next     = r_tx_byte;
    w_tx_valid_next    = r_tx_valid;
    w_sc_byte_next     = r_sc_byte;
    w_sc_valid_next    = 1'b0;
    w_kbd_ok_next      = r_kbd_ok;
    w_err_next         = r_err;
    w_led_shadow_next  = r_led_shadow;
    w_led_pending_next = r_led_pending;
    w_retry_next       = r_retry;
    w_tmr_clr          = 1'b0;
    w_led_start        = 1'b0;

    if (init_req_i) begin
      w_state_next    = RST_TX;
      w_tx_valid_next = 1'b0;
      w_retry_next    = '0;
      w_tmr_clr       = 1'b1;
      w_err_next      = 1'b0;
      w_kbd_ok_next   = 1'b0;
    end else begin
      if (w_forward) begin
        w_sc_valid_next = 1'b1;
        w_sc_byte_next  = rx_byte_i;
      end

      case (r_state)
        RST_TX, LED_TX, ARG_TX: begin
          if (w_accept) begin
            w_tx_valid_next = 1'b0;
            w_tmr_clr       = 1'b1;
            w_state_next    = tx_to_ack(r_state);
          end else if (!r_tx_valid) begin
            // Byte is latched once so it stays stable while the port stalls.
            w_tx_valid_next = 1'b1;
            case (r_state)
              RST_TX:  w_tx_byte_next = CMD_RESET;
              LED_TX:  w_tx_byte_next = CMD_LEDS;
              default: w_tx_byte_next = {5'b0, r_led_shadow};
            endcase
          end
        end

        RST_ACK, LED_ACK, ARG_ACK: begin
          if (w_rx_ack) begin
            w_retry_next = '0;
            case (r_state)
              RST_ACK: w_state_next = RST_BAT;
              LED_ACK: w_state_next = ARG_TX;
              default: w_state_next = IDLE;
            endcase
          end else if (w_nack) begin
            if (r_retry >= RW'(MAX_RETRY)) begin
              w_state_next  = FAIL;
              w_err_next    = 1'b1;
              w_kbd_ok_next = 1'b0;
            end else begin
              w_retry_next = r_retry + 1'b1;
              w_state_next = ack_to_tx(r_state);
            end
          end
        end

        RST_BAT: begin
          if (rx_valid_i && (rx_byte_i == RSP_BAT_OK)) begin
            w_kbd_ok_next = 1'b1;
            if (r_led_shadow != 3'b000) begin
              w_state_next = LED_TX;
              w_led_start  = 1'b1;
            end else begin
              w_state_next = IDLE;
            end
          end else if (rx_valid_i && (rx_byte_i == RSP_BAT_FAIL)) begin
            w_state_next  = FAIL;
            w_err_next    = 1'b1;
            w_kbd_ok_next = 1'b0;
          end
        end

        IDLE: begin
          // 0xAA here means the keyboard was re-plugged and lost its LED state.
          if ((rx_valid_i && (rx_byte_i == RSP_BAT_OK)) || r_led_pending) begin
            w_state_next = LED_TX;
            w_led_start  = 1'b1;
          end
        end

        FAIL: ;

        default: w_state_next = RST_TX;
      endcase

      if (leds_update_i) begin
        w_led_shadow_next  = leds_i;
        w_led_pending_next = 1'b1;
      end else if (w_led_start) begin
        w_led_pending_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= RST_TX;
      r_tx_byte     <= 8'h00;
      r_tx_valid    <= 1'b0;
      r_sc_byte     <= 8'h00;
      r_sc_valid    <= 1'b0;
      r_kbd_ok      <= 1'b0;
      r_err         <= 1'b0;
      r_led_shadow  <= 3'b000;
      r_led_pending <= 1'b0;
      r_retry       <= '0;
    end else begin
      r_state       <= w_state_next;
      r_tx_byte     <= w_tx_byte_next;
      r_tx_valid    <= w_tx_valid_next;
      r_sc_byte     <= w_sc_byte_next;
      r_sc_valid    <= w_sc_valid_next;
      r_kbd_ok      <= w_kbd_ok_next;
      r_err         <= w_err_next;
      r_led_shadow  <= w_led_shadow_next;
      r_led_pending <= w_led_pending_next;
      r_retry       <= w_retry_next;
    end
  end

  assign tx_byte_o  = r_tx_byte;
  assign tx_valid_o = r_tx_valid;
  assign sc_byte_o  = r_sc_byte;
  assign sc_valid_o = r_sc_valid;
  assign kbd_ok_o   = r_kbd_ok;
  assign err_o      = r_err;
  assign busy_o     = (r_state != IDLE) && (r_state != FAIL);

endmodule

// File: doc/ps2_kbd_ctrl.md
# ps2_kbd_ctrl

Command sequencer and traffic director for the PS2 keyboard port. It sits between the PS2 port byte interface and the scancode-to-keycode translator. After reset or on request it initialises the keyboard with the reset command and BAT check. It writes the LED state with the 0xED command, handling ACK, resend, timeout and retry limits. Scancode bytes pass to the translator only when they are not command responses.

## Interface
- TIMEOUT_CYC, 4_800_000, response timeout in clk cycles (100 ms at 48 MHz)
- MAX_RETRY, 3, retransmissions allowed per command byte before failure
- clk  in  1  system clock, 48 MHz
- reset  in  1  synchronous reset, active-high
- rx_byte_i  in  8  byte received from PS2 port
- rx_valid_i  in  1  single-cycle strobe for rx_byte_i
- tx_byte_o  out  8  byte to send to keyboard
- tx_valid_o  out  1  tx_byte_o valid; held until accepted
- tx_ready_i  in  1  port can accept a byte; transfer when tx_valid_o && tx_ready_i
- leds_i  in  3  requested LED mask {caps, num, scroll}
- leds_update_i  in  1  pulse: send leds_i to keyboard
- init_req_i  in  1  pulse: re-initialise keyboard
- sc_byte_o  out  8  scancode byte forwarded to translator
- sc_valid_o  out  1  single-cycle strobe for sc_byte_o
- kbd_ok_o  out  1  keyboard passed BAT and is idle-capable
- busy_o  out  1  command sequence in progress
- err_o  out  1  sticky failure flag; cleared by init_req_i or reset

## Operation
- States: RST_TX, RST_ACK, RST_BAT, IDLE, LED_TX, LED_ACK, ARG_TX, ARG_ACK, FAIL.
- RST_TX sends 0xFF, then goes to RST_ACK.
- RST_ACK on 0xFA goes to RST_BAT.
- RST_BAT on 0xAA sets kbd_ok_o=1 and goes to IDLE. If the LED shadow is nonzero, it instead goes to LED_TX.
- RST_BAT on 0xFC goes to FAIL.
- LED_TX sends 0xED. LED_ACK on 0xFA goes to ARG_TX.
- ARG_TX sends {5'b0, led_shadow}. ARG_ACK on 0xFA goes to IDLE.
- In any *_ACK state, 0xFE or a timeout causes retransmission of the current byte and increments the retry count.
- The retry count clears on each successful ACK. When the count exceeds MAX_RETRY, the block goes to FAIL.
- FAIL sets err_o=1 and kbd_ok_o=0. It leaves only on init_req_i.
- Response bytes 0xFA, 0xFE, 0xAA, 0xFC received in non-IDLE states are consumed.
- All other received bytes are forwarded on sc_* in every state except FAIL.
- In IDLE every byte is forwarded, except 0xAA. An 0xAA in IDLE is treated as a hot-plug and triggers an LED resend.
- leds_update_i captures leds_i into led_shadow and sets led_pending. A newer request overwrites both.
- led_pending is serviced on the next entry to IDLE, or immediately if already in IDLE.
- init_req_i is honoured in any state:
  - tx_valid_o drops
  - retry count, timer and err_o clear
  - kbd_ok_o is set to 0
  - the block goes to RST_TX
  - led_pending is kept
- init_req_i has priority over leds_update_i and over rx in the same cycle.
- busy_o=1 in every state except IDLE and FAIL.

## Timing
- Reset values:
  - state=RST_TX
  - tx_byte_o=0x00, tx_valid_o=0
  - sc_byte_o=0x00, sc_valid_o=0
  - kbd_ok_o=0, busy_o=1, err_o=0
  - led_shadow=0, led_pending=0
- tx_valid_o rises 1 cycle after entering a *_TX state. It stays high with a stable tx_byte_o until the accept cycle.
- The state advances to *_ACK on the cycle after accept.
- The timeout counter starts at 0 on accept and fires when it reaches TIMEOUT_CYC-1. The counter is held at 0 outside *_ACK states.
- sc_valid_o is registered: asserted 1 cycle after rx_valid_i.
- A response byte and a timeout in the same cycle resolve in favour of the byte.
- leds_update_i arriving in the same cycle as the ARG_ACK 0xFA still sets led_pending, so a second LED sequence follows.

## Structure
- ps2_pkg holds:
  - command constants: CMD_RESET=0xFF, CMD_LEDS=0xED
  - response constants: RSP_ACK=0xFA, RSP_RESEND=0xFE, RSP_BAT_OK=0xAA, RSP_BAT_FAIL=0xFC
  - the state encoding
- Sub-module ps2_cmd_timer: timeout counter with clear/enable inputs and an expire output, parameterised by TIMEOUT_CYC.

## Test plan
- Reset, tx_ready_i=1, keyboard replies 0xFA then 0xAA -> tx 0xFF once; kbd_ok_o=1, busy_o=0; no sc_valid_o.
- In IDLE, leds_i=3'b101 plus pulse -> tx 0xED; after 0xFA, tx 0x05; after 0xFA, back to IDLE with busy_o=0.
- During LED_ACK, reply 0xFE twice then 0xFA -> 0xED transmitted 3 times, sequence completes, err_o=0.
- With TIMEOUT_CYC=100 and no reply to 0xFF -> 4 transmissions, then FAIL with err_o=1; init_req_i restarts with err_o=0.
- Scancode 0x1C arrives during RST_BAT, then 0xAA -> sc_byte_o=0x1C pulsed once; 0xAA not forwarded.
- In IDLE with shadow 3'b010, 0xAA received -> 0xED, 0x02 sequence issued automatically.
